// File: rtl/legup_mult_stallable_pkg.sv
// legup_mult_pkg: shared width helpers for the stallable multiplier.
//   prodw          - full product width of an A x B multiply
//   occw           - width of an occupancy counter that can hold 0..pipeline
//   extend_product - sign- or zero-extend a pw-bit product, then keep wp LSBs
package legup_mult_pkg;

    // Widest product/result the extension helper handles.
    localparam int MAXW = 128;

    function automatic int prodw(input int wa, input int wb);
        return wa + wb;
    endfunction

    function automatic int occw(input int p);
        return $clog2(p + 1);
    endfunction

    function automatic logic [MAXW-1:0] extend_product(input logic [MAXW-1:0] prod,
                                                       input logic            sgn,
                                                       input int              pw,
                                                       input int              wp);
        logic signed [MAXW-1:0] sx;
        logic        [MAXW-1:0] r;
        logic        [MAXW-1:0] mask;
        // Park the product's MSB at bit MAXW-1 so an arithmetic shift back
        // replicates it; the unsigned path just keeps the zero padding.
        sx = prod << (MAXW - pw);
        if (sgn) begin
            sx = sx >>> (MAXW - pw);
            r  = sx;
        end else begin
            r = prod;
        end
        mask = ~({MAXW{1'b1}} << wp);
        return r & mask;
    endfunction

endpackage

// File: rtl/legup_mult_stallable_if.sv
// legup_mult_stallable_if: operand/result handshake bundle.
//   slave  - multiplier view (takes operands, drives result/occupancy)
//   master - producer/consumer view
interface legup_mult_stallable_if #(
    parameter int widtha   = 32,
    parameter int widthb   = 32,
    parameter int widthp   = 64,
    parameter int widtht   = 8,
    parameter int pipeline = 3
) ();
    import legup_mult_pkg::*;
    localparam int OW = occw(pipeline);

    logic              in_valid;
    logic              in_ready;
    logic [widtha-1:0] dataa;
    logic [widthb-1:0] datab;
    logic              op_signed;
    logic [widtht-1:0] in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [widthp-1:0] result;
    logic [widtht-1:0] out_tag;
    logic [OW-1:0]     occupancy;

    modport slave (
        input  in_valid, dataa, datab, op_signed, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, occupancy
    );

    modport master (
        output in_valid, dataa, datab, op_signed, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, occupancy
    );
endinterface

// File: rtl/legup_mult_stallable_stage.sv
// legup_mult_elastic_stage: one elastic pipeline register (data + valid).
//   ld       - load enable (stage empty, or downstream takes its content)
//   in_valid - valid bit of the upstream stage
//   in_data  - upstream payload
//   out_*    - registered valid/payload
module legup_mult_elastic_stage #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);
    logic          vld_q, vld_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (ld) begin
            vld_d = in_valid;
            // Bubbles leave the payload alone to avoid needless toggling.
            if (in_valid) data_d = in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
endmodule

// File: rtl/legup_mult_stallable.sv
// legup_mult_stallable: elastic, stallable pipelined multiplier.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus (slave)  - in_valid/in_ready operand handshake with dataa, datab,
//                  op_signed, in_tag; out_valid/out_ready result handshake
//                  with result, out_tag; occupancy = operations in flight.
// Stage 0 holds operands; the product is formed from stage 0 and carried with
// its tag through stages 1..pipeline-1. Any empty stage ahead lets everything
// behind it advance, so bubbles collapse under backpressure.
module legup_mult_stallable
    import legup_mult_pkg::*;
#(
    parameter int widtha   = 32,
    parameter int widthb   = 32,
    parameter int widthp   = 64,
    parameter int pipeline = 3,
    parameter int widtht   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    legup_mult_stallable_if.slave bus
);
    localparam int PW = prodw(widtha, widthb);
    localparam int OW = occw(pipeline);
    localparam int DW = widtht + widthp;

    logic [pipeline-1:0] ld;    // stage i loads this edge
    logic [pipeline-1:0] vld;   // stage valid bits
    logic [DW-1:0]       sd [pipeline];

    // Stage i may load iff the consumer takes or some stage at/after i is
    // empty; that is the unrolled form of !valid[i] || load[i+1].
    always_comb begin
        logic hole;
        hole = 1'b0;
        for (int i = pipeline - 1; i >= 0; i--) begin
            hole  = hole | ~vld[i];
            ld[i] = hole | bus.out_ready;
        end
    end

    // Stage 0: operands, mode and tag.
    logic              v0_q, v0_d, s_q, s_d;
    logic [widtha-1:0] a_q, a_d;
    logic [widthb-1:0] b_q, b_d;
    logic [widtht-1:0] t_q, t_d;

    always_comb begin
        v0_d = v0_q;
        s_d  = s_q;
        a_d  = a_q;
        b_d  = b_q;
        t_d  = t_q;
        if (ld[0]) begin
            v0_d = bus.in_valid;
            if (bus.in_valid) begin
                s_d = bus.op_signed;
                a_d = bus.dataa;
                b_d = bus.datab;
                t_d = bus.in_tag;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v0_q <= 1'b0;
            s_q  <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            t_q  <= '0;
        end else begin
            v0_q <= v0_d;
            s_q  <= s_d;
            a_q  <= a_d;
            b_q  <= b_d;
            t_q  <= t_d;
        end
    end

    assign vld[0] = v0_q;

    // Operands extended to the full product width: the low PW bits of that
    // product are exact for both signed and unsigned modes.
    logic              a_sgn, b_sgn;
    logic [PW-1:0]     ma, mb, full;
    logic [widthp-1:0] prod_ext;

    always_comb begin
        a_sgn    = s_q & a_q[widtha-1];
        b_sgn    = s_q & b_q[widthb-1];
        ma       = {{widthb{a_sgn}}, a_q};
        mb       = {{widtha{b_sgn}}, b_q};
        full     = ma * mb;
        prod_ext = widthp'(extend_product(MAXW'(full), s_q, PW, widthp));
    end

    // With pipeline = 1 this product is the output directly.
    assign sd[0] = {t_q, prod_ext};

    for (genvar i = 1; i < pipeline; i++) begin : g_stage
        legup_mult_elastic_stage #(.DW(DW)) u_stage (
            .clock     (clock),
            .reset     (reset),
            .ld        (ld[i]),
            .in_valid  (vld[i-1]),
            .in_data   (sd[i-1]),
            .out_valid (vld[i]),
            .out_data  (sd[i])
        );
    end

    assign bus.out_valid           = vld[pipeline-1];
    assign {bus.out_tag, bus.result} = sd[pipeline-1];
    assign bus.in_ready            = ~reset & ld[0];

    // Occupancy tracks handshakes, which keeps it equal to popcount(vld).
    logic [OW-1:0] occ_q, occ_d;
    logic          acc, emit;

    always_comb begin
        acc   = bus.in_valid & bus.in_ready;
        emit  = bus.out_valid & bus.out_ready;
        occ_d = occ_q;
        if (acc & ~emit)      occ_d = occ_q + OW'(1);
        else if (~acc & emit) occ_d = occ_q - OW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_legup_mult_stallable.sv
module tb_legup_mult_stallable;
    localparam int P = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    legup_mult_stallable_if #(.widtha(8), .widthb(8), .widthp(16), .widtht(8), .pipeline(P)) bus ();
    legup_mult_stallable_if #(.widtha(8), .widthb(8), .widthp(8),  .widtht(8), .pipeline(1)) bus2 ();

    // Second instance (8-bit result, single stage) shares the operand stream.
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.dataa     = bus.dataa;
    assign bus2.datab     = bus.datab;
    assign bus2.op_signed = bus.op_signed;
    assign bus2.in_tag    = bus.in_tag;
    assign bus2.out_ready = 1'b1;

    legup_mult_stallable #(.widtha(8), .widthb(8), .widthp(16), .pipeline(P), .widtht(8)) dut (
        .clock (clock), .reset (reset), .bus (bus));
    legup_mult_stallable #(.widtha(8), .widthb(8), .widthp(8), .pipeline(1), .widtht(8)) dut2 (
        .clock (clock), .reset (reset), .bus (bus2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mulref(input logic [7:0] a, input logic [7:0] b, input logic s);
        int pa;
        if (s) pa = int'($signed(a)) * int'($signed(b));
        else   pa = int'(a) * int'(b);
        return 32'(pa);
    endfunction

    // Reference model: in-flight ops in order, each with edges since accept.
    typedef struct {
        logic [15:0] res;
        logic [7:0]  tag;
        int          age;
    } ent_t;
    ent_t        q1[$];
    logic [7:0]  q2r[$];
    logic [7:0]  q2t[$];

    always @(posedge clock) begin
        logic [31:0] r;
        bit          acc1, emit1;
        ent_t        e;
        if (reset) begin
            q1.delete();
            q2r.delete();
            q2t.delete();
        end else begin
            acc1  = bus.in_valid && (q1.size() < P || bus.out_ready);
            emit1 = q1.size() > 0 && q1[0].age >= P - 1 && bus.out_ready;
            r     = mulref(bus.dataa, bus.datab, bus.op_signed);
            if (emit1) void'(q1.pop_front());
            foreach (q1[i]) q1[i].age++;
            if (acc1) begin
                e.res = r[15:0];
                e.tag = bus.in_tag;
                e.age = 0;
                q1.push_back(e);
            end
            if (q2r.size() > 0) begin
                void'(q2r.pop_front());
                void'(q2t.pop_front());
            end
            if (bus.in_valid) begin
                q2r.push_back(r[7:0]);
                q2t.push_back(bus.in_tag);
            end
        end
    end

    always @(negedge clock) begin
        bit ev;
        if (chk_en) begin
            ev = q1.size() > 0 && q1[0].age >= P - 1;
            chk("in_ready", 64'(bus.in_ready), 64'(!reset && (q1.size() < P || bus.out_ready)));
            chk("out_valid", 64'(bus.out_valid), 64'(ev));
            chk("occupancy", 64'(bus.occupancy), 64'(q1.size()));
            if (ev) begin
                chk("result", 64'(bus.result), 64'(q1[0].res));
                chk("out_tag", 64'(bus.out_tag), 64'(q1[0].tag));
            end
            chk("p1_in_ready", 64'(bus2.in_ready), 64'(!reset));
            chk("p1_out_valid", 64'(bus2.out_valid), 64'(q2r.size() > 0));
            chk("p1_occupancy", 64'(bus2.occupancy), 64'(q2r.size()));
            if (q2r.size() > 0) begin
                chk("p1_result", 64'(bus2.result), 64'(q2r[0]));
                chk("p1_out_tag", 64'(bus2.out_tag), 64'(q2t[0]));
            end
        end
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    // Present one op and return just after the edge that accepted it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [7:0] t);
        int n;
        bus.in_valid  = 1'b1;
        bus.dataa     = a;
        bus.datab     = b;
        bus.op_signed = s;
        bus.in_tag    = t;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed %0d for %0d cycles", bus.in_ready, n);
        end
        cyc();
    endtask

    task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [7:0] t,
                            input logic [15:0] e16, input logic [7:0] e8);
        logic [31:0] r;
        r = mulref(a, b, s);
        chk("model16", 64'(r[15:0]), 64'(e16));
        chk("model8", 64'(r[7:0]), 64'(e8));
        send(a, b, s, t);
        chk("p1_lit_valid", 64'(bus2.out_valid), 64'(1));
        chk("p1_lit_result", 64'(bus2.result), 64'(e8));
        bus.in_valid = 1'b0;
        cyc();
        chk("lat_early", 64'(bus.out_valid), 64'(0));
        cyc();
        chk("lat_valid", 64'(bus.out_valid), 64'(1));
        chk("lit_result", 64'(bus.result), 64'(e16));
        chk("lit_tag", 64'(bus.out_tag), 64'(t));
        cyc();
        cyc();
    endtask

    initial begin
        int acc_n, seen;
        bit w, pend;
        bus.in_valid  = 1'b0;
        bus.dataa     = '0;
        bus.datab     = '0;
        bus.op_signed = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        cyc();
        cyc();
        chk_en = 1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_occupancy", 64'(bus.occupancy), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
        reset = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'(1));

        // Unsigned, signed and truncation cases.
        directed(8'hFF, 8'hFF, 1'b0, 8'h11, 16'hFE01, 8'h01);
        directed(8'hFF, 8'h02, 1'b1, 8'h22, 16'hFFFE, 8'hFE);
        directed(8'hFF, 8'h02, 1'b0, 8'h33, 16'h01FE, 8'hFE);
        directed(8'h80, 8'h80, 1'b1, 8'h44, 16'h4000, 8'h00);

        // Back-to-back stream.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom), 8'(i));
            if (i == 50) chk("stream_occ", 64'(bus.occupancy), 64'(P));
        end
        bus.in_valid = 1'b0;
        repeat (5) cyc();

        // Backpressure fill.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.dataa     = 8'($urandom);
        bus.datab     = 8'($urandom);
        bus.op_signed = 1'($urandom);
        bus.in_tag    = 8'hA0;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            w = bus.in_ready;
            cyc();
            if (w) begin
                acc_n++;
                bus.dataa  = 8'($urandom);
                bus.datab  = 8'($urandom);
                bus.in_tag = 8'(8'hA0 + acc_n);
            end
        end
        chk("fill_accepts", 64'(acc_n), 64'(3));
        chk("fill_occ", 64'(bus.occupancy), 64'(3));
        chk("fill_in_ready", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
        #1;
        chk("ready_same_cycle", 64'(bus.in_ready), 64'(1));
        cyc();
        bus.in_valid = 1'b0;
        repeat (6) cyc();

        // Bubble collapse.
        bus.out_ready = 1'b0;
        send(8'd3, 8'd5, 1'b0, 8'd1);
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        send(8'd7, 8'd9, 1'b0, 8'd2);
        bus.in_valid = 1'b0;
        repeat (4) cyc();
        chk("bub_occ", 64'(bus.occupancy), 64'(2));
        chk("bub_first", 64'(bus.result), 64'(15));
        bus.out_ready = 1'b1;
        cyc();
        chk("bub_next_valid", 64'(bus.out_valid), 64'(1));
        chk("bub_next_result", 64'(bus.result), 64'(63));
        chk("bub_next_tag", 64'(bus.out_tag), 64'(2));
        repeat (3) cyc();

        // Reset mid-flight.
        bus.out_ready = 1'b0;
        send(8'd12, 8'd12, 1'b0, 8'h55);
        send(8'd13, 8'd13, 1'b0, 8'h66);
        bus.in_valid = 1'b0;
        chk("pre_rst_occ", 64'(bus.occupancy), 64'(2));
        reset = 1'b1;
        cyc();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_occ", 64'(bus.occupancy), 64'(0));
        chk("mid_rst_result", 64'(bus.result), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            cyc();
            if (bus.out_valid) seen++;
        end
        chk("stale_products", 64'(seen), 64'(0));

        // Random traffic with random backpressure.
        pend = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.dataa     = 8'($urandom);
                bus.datab     = 8'($urandom);
                bus.op_signed = 1'($urandom);
                bus.in_tag    = 8'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            w = bus.in_valid && bus.in_ready;
            pend = bus.in_valid && !w;
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/legup_mult_stallable.md
# legup_mult_stallable

Stallable, elastic pipelined multiplier for HLS-generated datapaths. Downstream backpressure can freeze the block without losing or duplicating products, and empty stages collapse. Each operation selects signed or unsigned multiplication at run time and carries a user tag alongside the operands. It sits between an HLS pipeline's issue stage and its consumer, and adds a valid/ready handshake and occupancy tracking that the plain pipelined multiplier lacks.

## Interface
- `widtha`, 32, operand A width (≥1)
- `widthb`, 32, operand B width (≥1)
- `widthp`, 64, result width; product is truncated or extended to this width
- `pipeline`, 3, register stages; latency in cycles (≥1)
- `widtht`, 8, sideband tag width (≥1)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands presented
- `in_ready`  out  1  block accepts this cycle
- `dataa`  in  widtha  operand A
- `datab`  in  widthb  operand B
- `op_signed`  in  1  1 = two's-complement multiply, 0 = unsigned
- `in_tag`  in  widtht  sideband, returned with the product
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts
- `result`  out  widthp  product
- `out_tag`  out  widtht  tag of the presented result
- `occupancy`  out  $clog2(pipeline+1)  in-flight operations

## Operation
- **Stages.** Stage 0 registers operands, mode and tag. The full product (widtha+widthb bits) is formed from stage-0 registers and loaded into stage 1, or into the output register when pipeline = 1. Stages 2..pipeline-1 only delay the product. Each stage has a valid bit.
- **Advance.** Stage i loads when it is empty or stage i+1 (or the consumer, for the last stage) takes its content this cycle.
  - Result: bubbles collapse, so a stalled pipe fills to exactly `pipeline` entries.
  - in_ready = !valid[0] || advance[0]. This is a combinational path from out_ready.
- **Width rules.**
  - signed: operands sign-extended, product sign-extended/truncated to widthp.
  - unsigned: zero-extended.
  - Truncation keeps the LSBs.
- **Ordering.** Strict FIFO order. out_tag always belongs to result.
- **Occupancy.** Counter +1 on input handshake, −1 on output handshake, unchanged when both occur or neither does. It always equals the popcount of the stage valid bits.
- **Reset.**
  - All valid bits = 0, occupancy = 0, result = 0, out_tag = 0, out_valid = 0.
  - in_ready reads 1 in the first cycle after reset is released.
  - in_ready = 0 while reset is high.
  - Reset mid-operation discards all in-flight operations; none ever emerges.

## Timing
- Operation accepted at edge t emerges with out_valid = 1 after edge t+pipeline−1 (visible for `pipeline` cycles counting the accept cycle) when no stall intervenes.
- Throughput: one result per cycle while out_ready = 1.
- Stall:
  - out_valid && !out_ready holds result and out_tag stable.
  - out_valid never drops without a handshake.
- Full (occupancy = pipeline, out_ready = 0): in_ready = 0. in_ready returns to 1 in the same cycle out_ready rises.
- Simultaneous accept and emit while full: allowed, occupancy unchanged.
- in_valid with in_ready = 0: no acceptance; the source must hold its operands.

## Structure
- Package `legup_mult_pkg`:
  - product-width function `prodw(widtha, widthb)`
  - function `extend_product(prod, signed, widthp)`
  - occupancy width function
- Sub-module `legup_mult_elastic_stage`:
  - one data+valid register with load = !valid || next_take
  - parameterised data width
  - instantiated in a generate loop over 1..pipeline−1

## Test plan
- **Unsigned flow.** widtha=widthb=8, widthp=16, pipeline=3, out_ready=1; 0xFF×0xFF, tag 0x11 → result 0xFE01, out_tag 0x11, three cycles after the accept cycle.
- **Signed and truncation.** op_signed=1, 0xFF×0x02, widthp=16 → 0xFFFE. Same inputs with op_signed=0 → 0x01FE. With widthp=8 → 0xFE.
- **Back-to-back.** Stream 100 random operations with out_ready=1 → one result per cycle, in order, matching a reference model; occupancy constant at 3.
- **Backpressure fill.** out_ready=0, in_valid held → exactly 3 accepts, then in_ready=0 and occupancy=3; result stable. Raising out_ready → in_ready=1 the same cycle, and results drain in order.
- **Bubble collapse.** Issue ops 1 and 2 with a 2-cycle gap while out_ready=0 → both stack adjacently; occupancy=2; the next result follows one cycle after the first drains.
- **Reset mid-flight.** Pulse reset with occupancy=2 → next cycle out_valid=0, occupancy=0, result=0; no stale product appears afterwards.
